alu_controller_mc: RTL and testbench

ALU_CONTROLLER_MC -- requirements
Module: alu_controller_mc

---
 rtl/alu_controller_mc.sv | 137 +++++++++++++
 tb/tb_alu_controller_mc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_controller_mc.sv
// Multi-cycle ALU controller: funct/ALUop decode, DELAY-stage output pipeline, mult/div handshake FSM.
// Optional unsupported-funct detection is built when ALU_CTRL_ILLEGAL_EN is defined.
`timescale 1ns/1ps
module alu_controller_mc #(
  parameter int          FUNCT_WIDTH    = 6,
  parameter int          ALUOP_WIDTH    = 6,
  parameter int          ALUFUNCT_WIDTH = 6,
  parameter int unsigned DELAY          = 0,
  parameter int unsigned MULDIV_CYCLES  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [FUNCT_WIDTH-1:0]    funct,
  input  logic [ALUOP_WIDTH-1:0]    ALUop,
  input  logic                      md_done,
  output logic                      stall,
  output logic                      valid_out,
  output logic [ALUFUNCT_WIDTH-1:0] ALUfunct,
  output logic                      jr,
  output logic                      md_start,
  output logic                      md_timeout,
  output logic                      illegal
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]                state;
  logic [7:0]                cnt;
  logic [31:0]               fx;
  logic                      rtype, is_md, is_hilo, accept;
  logic                      dec_v, dec_jr, dec_ill;
  logic [ALUFUNCT_WIDTH-1:0] dec_f;

  assign fx      = 32'(funct);
  assign rtype   = (ALUop == '0);
  assign is_md   = rtype && (fx >= 32'h18) && (fx <= 32'h1B);
  assign is_hilo = rtype && (fx >= 32'h10) && (fx <= 32'h13);
  assign stall   = (state == BUSY) && valid_in && (is_md || is_hilo);
  // rst gates accept so the DELAY=0 combinational outputs also read 0 while in reset
  assign accept  = valid_in && !stall && !rst;

  assign dec_v  = accept;
  assign dec_f  = !accept ? '0 : (rtype ? ALUFUNCT_WIDTH'(funct) : ALUFUNCT_WIDTH'(ALUop));
  assign dec_jr = accept && rtype && (fx == 32'h08);

`ifdef ALU_CTRL_ILLEGAL_EN
  logic legal;
  always_comb begin
    legal = 1'b0;
    case (fx)
      32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07, 32'h08, 32'h09,
      32'h10, 32'h11, 32'h12, 32'h13, 32'h18, 32'h19, 32'h1A, 32'h1B,
      32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27,
      32'h2A, 32'h2B: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end
  assign dec_ill = accept && rtype && !legal;
`else
  assign dec_ill = 1'b0;
`endif

  generate
    if (DELAY == 0) begin : g_comb
      assign valid_out = dec_v;
      assign ALUfunct  = dec_f;
      assign jr        = dec_jr;
      assign illegal   = dec_ill;
    end else begin : g_pipe
      logic                      pv [1:DELAY];
      logic [ALUFUNCT_WIDTH-1:0] pf [1:DELAY];
      logic                      pj [1:DELAY];
      logic                      pi [1:DELAY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 1; i <= DELAY; i++) begin
            pv[i] <= 1'b0;
            pf[i] <= '0;
            pj[i] <= 1'b0;
            pi[i] <= 1'b0;
          end
        end else begin
          pv[1] <= dec_v;
          pf[1] <= dec_f;
          pj[1] <= dec_jr;
          pi[1] <= dec_ill;
          for (int unsigned i = 2; i <= DELAY; i++) begin
            pv[i] <= pv[i-1];
            pf[i] <= pf[i-1];
            pj[i] <= pj[i-1];
            pi[i] <= pi[i-1];
          end
        end
      end

      assign valid_out = pv[DELAY];
      assign ALUfunct  = pf[DELAY];
      assign jr        = pj[DELAY];
      assign illegal   = pi[DELAY];
    end
  endgenerate

  // Counter holds the BUSY cycles left; expiry at 1 gives exactly MULDIV_CYCLES BUSY cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      md_start   <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      md_start   <= 1'b0;
      md_timeout <= 1'b0;
      if (state == IDLE) begin
        if (accept && is_md) begin
          state    <= BUSY;
          cnt      <= 8'(MULDIV_CYCLES);
          md_start <= 1'b1;
        end
      end else begin
        if (md_done) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt <= 8'd1) begin
          state      <= IDLE;
          cnt        <= '0;
          md_timeout <= 1'b1;
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_controller_mc.sv
// Directed bench for alu_controller_mc: three instances (DELAY 0/2/3, MULDIV_CYCLES 4) on shared inputs.
`timescale 1ns/1ps
module tb_alu_controller_mc;

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic       clk, rst, valid_in, md_done;
  logic [5:0] funct, aluop;

  logic       u0_st, u0_vo, u0_jr, u0_ms, u0_mt, u0_il;
  logic       u2_st, u2_vo, u2_jr, u2_ms, u2_mt, u2_il;
  logic       u3_st, u3_vo, u3_jr, u3_ms, u3_mt, u3_il;
  logic [5:0] u0_af, u2_af, u3_af;
  logic [11:0] o0, o2, o3;

  int checks = 0;
  int errors = 0;

  assign o0 = {u0_st, u0_vo, u0_af, u0_jr, u0_ms, u0_mt, u0_il};
  assign o2 = {u2_st, u2_vo, u2_af, u2_jr, u2_ms, u2_mt, u2_il};
  assign o3 = {u3_st, u3_vo, u3_af, u3_jr, u3_ms, u3_mt, u3_il};

  alu_controller_mc #(.DELAY(0), .MULDIV_CYCLES(4)) u0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct(funct), .ALUop(aluop), .md_done(md_done),
    .stall(u0_st), .valid_out(u0_vo), .ALUfunct(u0_af), .jr(u0_jr), .md_start(u0_ms),
    .md_timeout(u0_mt), .illegal(u0_il));

  alu_controller_mc #(.DELAY(2), .MULDIV_CYCLES(4)) u2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct(funct), .ALUop(aluop), .md_done(md_done),
    .stall(u2_st), .valid_out(u2_vo), .ALUfunct(u2_af), .jr(u2_jr), .md_start(u2_ms),
    .md_timeout(u2_mt), .illegal(u2_il));

  alu_controller_mc #(.DELAY(3), .MULDIV_CYCLES(4)) u3 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct(funct), .ALUop(aluop), .md_done(md_done),
    .stall(u3_st), .valid_out(u3_vo), .ALUfunct(u3_af), .jr(u3_jr), .md_start(u3_ms),
    .md_timeout(u3_mt), .illegal(u3_il));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [5:0] op, input logic d);
    valid_in = v;
    funct    = f;
    aluop    = op;
    md_done  = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    repeat (n) nxt();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 6'h20, 6'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o0 !== 12'h000) begin errors++; $display("FAIL reset_u0 got %h exp 000", o0); end
    checks++; if (o2 !== 12'h000) begin errors++; $display("FAIL reset_u2 got %h exp 000", o2); end
    checks++; if (o3 !== 12'h000) begin errors++; $display("FAIL reset_u3 got %h exp 000", o3); end
    rst = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    nxt();
  endtask

  task automatic test_decode;
    drive(1'b1, 6'h20, 6'h00, 1'b0); #1;
    checks++; if (u0_vo !== 1'b1) begin errors++; $display("FAIL dec_add_vo got %b exp 1", u0_vo); end
    checks++; if (u0_af !== 6'h20) begin errors++; $display("FAIL dec_add_af got %h exp 20", u0_af); end
    checks++; if (u0_jr !== 1'b0) begin errors++; $display("FAIL dec_add_jr got %b exp 0", u0_jr); end
    drive(1'b1, 6'h08, 6'h23, 1'b0); #1;
    checks++; if (u0_af !== 6'h23) begin errors++; $display("FAIL dec_op_af got %h exp 23", u0_af); end
    checks++; if (u0_jr !== 1'b0) begin errors++; $display("FAIL dec_op_jr got %b exp 0", u0_jr); end
    drive(1'b1, 6'h08, 6'h00, 1'b0); #1;
    checks++; if (u0_jr !== 1'b1) begin errors++; $display("FAIL dec_jr got %b exp 1", u0_jr); end
    checks++; if (u0_af !== 6'h08) begin errors++; $display("FAIL dec_jr_af got %h exp 08", u0_af); end
    drive(1'b0, 6'h20, 6'h00, 1'b0); #1;
    checks++; if (u0_vo !== 1'b0) begin errors++; $display("FAIL dec_novalid got %b exp 0", u0_vo); end
    idle(4);
  endtask

  task automatic test_delay2;
    drive(1'b1, 6'h08, 6'h00, 1'b0); smp();
    checks++; if (u2_vo !== 1'b0) begin errors++; $display("FAIL d2_c0_vo got %b exp 0", u2_vo); end
    nxt(); drive(1'b0, 6'h00, 6'h00, 1'b0); smp();
    checks++; if (u2_vo !== 1'b0) begin errors++; $display("FAIL d2_c1_vo got %b exp 0", u2_vo); end
    nxt(); smp();
    checks++; if (u2_vo !== 1'b1) begin errors++; $display("FAIL d2_c2_vo got %b exp 1", u2_vo); end
    checks++; if (u2_jr !== 1'b1) begin errors++; $display("FAIL d2_c2_jr got %b exp 1", u2_jr); end
    checks++; if (u2_af !== 6'h08) begin errors++; $display("FAIL d2_c2_af got %h exp 08", u2_af); end
    checks++; if (u3_vo !== 1'b0) begin errors++; $display("FAIL d3_c2_vo got %b exp 0", u3_vo); end
    nxt(); smp();
    checks++; if (u2_vo !== 1'b0) begin errors++; $display("FAIL d2_c3_vo got %b exp 0", u2_vo); end
    checks++; if (u3_vo !== 1'b1 || u3_jr !== 1'b1) begin errors++; $display("FAIL d3_c3 got vo=%b jr=%b exp 1 1", u3_vo, u3_jr); end
    nxt(); idle(4);
  endtask

  task automatic test_md;
    drive(1'b1, 6'h18, 6'h00, 1'b0); smp();
    checks++; if (u0_st !== 1'b0 || u0_vo !== 1'b1) begin errors++; $display("FAIL md_c0 got st=%b vo=%b exp 0 1", u0_st, u0_vo); end
    nxt(); drive(1'b1, 6'h20, 6'h00, 1'b0); smp();
    checks++; if (u0_ms !== 1'b1) begin errors++; $display("FAIL md_start got %b exp 1", u0_ms); end
    checks++; if (u0_st !== 1'b0 || u0_vo !== 1'b1 || u0_af !== 6'h20) begin errors++; $display("FAIL md_busy_add got st=%b vo=%b af=%h exp 0 1 20", u0_st, u0_vo, u0_af); end
    nxt(); drive(1'b1, 6'h10, 6'h00, 1'b0); smp();
    checks++; if (u0_st !== 1'b1 || u0_vo !== 1'b0) begin errors++; $display("FAIL md_hilo_stall got st=%b vo=%b exp 1 0", u0_st, u0_vo); end
    checks++; if (u0_ms !== 1'b0) begin errors++; $display("FAIL md_start_pulse got %b exp 0", u0_ms); end
    nxt(); drive(1'b1, 6'h10, 6'h00, 1'b1); smp();
    checks++; if (u0_st !== 1'b1 || u0_vo !== 1'b0) begin errors++; $display("FAIL md_done_cycle got st=%b vo=%b exp 1 0", u0_st, u0_vo); end
    nxt(); drive(1'b1, 6'h10, 6'h00, 1'b0); smp();
    checks++; if (u0_st !== 1'b0 || u0_vo !== 1'b1 || u0_af !== 6'h10) begin errors++; $display("FAIL md_after_done got st=%b vo=%b af=%h exp 0 1 10", u0_st, u0_vo, u0_af); end
    checks++; if (u0_mt !== 1'b0) begin errors++; $display("FAIL md_no_timeout got %b exp 0", u0_mt); end
    nxt(); idle(6);
  endtask

  task automatic test_timeout;
    drive(1'b1, 6'h19, 6'h00, 1'b0); smp();
    checks++; if (u0_st !== 1'b0) begin errors++; $display("FAIL to_accept got st=%b exp 0", u0_st); end
    nxt();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 6'h1A, 6'h00, 1'b0); smp();
      checks++; if (u0_st !== 1'b1 || u0_mt !== 1'b0 || u0_vo !== 1'b0) begin errors++; $display("FAIL to_busy%0d got st=%b mt=%b vo=%b exp 1 0 0", k, u0_st, u0_mt, u0_vo); end
      nxt();
    end
    drive(1'b1, 6'h12, 6'h00, 1'b0); smp();
    checks++; if (u0_mt !== 1'b1 || u0_st !== 1'b0 || u0_vo !== 1'b1) begin errors++; $display("FAIL to_pulse got mt=%b st=%b vo=%b exp 1 0 1", u0_mt, u0_st, u0_vo); end
    nxt(); drive(1'b0, 6'h00, 6'h00, 1'b0); smp();
    checks++; if (u0_mt !== 1'b0 || u0_ms !== 1'b0) begin errors++; $display("FAIL to_after got mt=%b ms=%b exp 0 0", u0_mt, u0_ms); end
    nxt(); idle(4);
  endtask

  task automatic test_coincident;
    drive(1'b1, 6'h1B, 6'h00, 1'b0); nxt();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 6'h10, 6'h00, 1'b0); smp();
      checks++; if (u0_st !== 1'b1) begin errors++; $display("FAIL co_busy%0d got st=%b exp 1", k, u0_st); end
      nxt();
    end
    drive(1'b1, 6'h10, 6'h00, 1'b1); smp();
    checks++; if (u0_st !== 1'b1) begin errors++; $display("FAIL co_last got st=%b exp 1", u0_st); end
    nxt(); drive(1'b1, 6'h10, 6'h00, 1'b0); smp();
    checks++; if (u0_mt !== 1'b0 || u0_st !== 1'b0 || u0_vo !== 1'b1) begin errors++; $display("FAIL co_done got mt=%b st=%b vo=%b exp 0 0 1", u0_mt, u0_st, u0_vo); end
    nxt(); drive(1'b0, 6'h00, 6'h00, 1'b0); smp();
    checks++; if (u0_mt !== 1'b0) begin errors++; $display("FAIL co_after got mt=%b exp 0", u0_mt); end
    nxt(); idle(4);
  endtask

  task automatic test_idle_done;
    drive(1'b0, 6'h00, 6'h00, 1'b1); nxt();
    drive(1'b1, 6'h10, 6'h00, 1'b0); smp();
    checks++; if (u0_st !== 1'b0 || u0_ms !== 1'b0 || u0_mt !== 1'b0 || u0_vo !== 1'b1) begin errors++; $display("FAIL idle_done got st=%b ms=%b mt=%b vo=%b exp 0 0 0 1", u0_st, u0_ms, u0_mt, u0_vo); end
    nxt(); idle(4);
  endtask

  task automatic test_reset_busy;
    drive(1'b1, 6'h18, 6'h00, 1'b0); nxt();
    drive(1'b1, 6'h20, 6'h00, 1'b0); nxt();
    drive(1'b1, 6'h08, 6'h00, 1'b0); smp();
    checks++; if (u3_vo !== 1'b0 || u0_st !== 1'b0) begin errors++; $display("FAIL rb_pre got vo=%b st=%b exp 0 0", u3_vo, u0_st); end
    rst = 1'b1; #1;
    checks++; if (o3 !== 12'h000) begin errors++; $display("FAIL rb_u3 got %h exp 000", o3); end
    checks++; if (o0 !== 12'h000) begin errors++; $display("FAIL rb_u0 got %h exp 000", o0); end
    checks++; if (o2 !== 12'h000) begin errors++; $display("FAIL rb_u2 got %h exp 000", o2); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'h00, 6'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (u3_vo !== 1'b0 || u3_mt !== 1'b0 || u0_mt !== 1'b0 || u3_ms !== 1'b0) begin errors++; $display("FAIL rb_post%0d got vo=%b mt3=%b mt0=%b ms=%b exp 0 0 0 0", k, u3_vo, u3_mt, u0_mt, u3_ms); end
    end
    nxt(); idle(2);
  endtask

  task automatic test_illegal;
    drive(1'b1, 6'h05, 6'h00, 1'b0); smp();
    checks++; if (u0_vo !== 1'b1 || u0_il !== ILL) begin errors++; $display("FAIL ill_05 got vo=%b il=%b exp 1 %b", u0_vo, u0_il, ILL); end
    nxt(); drive(1'b1, 6'h20, 6'h00, 1'b0); smp();
    checks++; if (u0_il !== 1'b0) begin errors++; $display("FAIL ill_20 got %b exp 0", u0_il); end
    nxt(); drive(1'b0, 6'h00, 6'h00, 1'b0); smp();
    checks++; if (u2_vo !== 1'b1 || u2_il !== ILL) begin errors++; $display("FAIL ill_d2 got vo=%b il=%b exp 1 %b", u2_vo, u2_il, ILL); end
    nxt(); idle(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_delay2();
    test_md();
    test_timeout();
    test_coincident();
    test_idle_done();
    test_reset_busy();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
